// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response interface
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic [DATA_WIDTH-1:0] addr;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with single-outstanding imem access and IF/ID register
module fetch_stage #(
  parameter int                   DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_src_i,
  input  logic [DATA_WIDTH-1:0] pc_target_i,
  input  logic                  stall_d_i,
  input  logic                  flush_d_i,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] instr_d_o,
  output logic [DATA_WIDTH-1:0] pc_d_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_d_o,
  output logic                  valid_d_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [DATA_WIDTH-1:0] pc_if_q, pc_if_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [DATA_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [DATA_WIDTH-1:0] instr_d_q, instr_d_d;
  logic [DATA_WIDTH-1:0] pc_d_q, pc_d_d;
  logic [DATA_WIDTH-1:0] pc_plus4_d_q, pc_plus4_d_d;
  logic                  valid_d_q, valid_d_d;

  logic                  new_vld;
  logic [DATA_WIDTH-1:0] new_instr;
  logic [DATA_WIDTH-1:0] new_pc;
  logic                  ifid_free;

  assign ifid_free = ~valid_d_q | ~stall_d_i;

  // A redirect cycle never issues a request, so the target is what gets fetched next.
  assign imem.req  = rst_n & (state_q == S_REQ) & ~pc_src_i;
  assign imem.addr = pc_f_q;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    pc_if_d     = pc_if_q;
    drop_d      = drop_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    new_vld     = 1'b0;
    new_instr   = imem.rdata;
    new_pc      = pc_if_q;

    case (state_q)
      S_REQ: begin
        if (!pc_src_i && imem.gnt) begin
          pc_if_d = pc_f_q;
          pc_f_d  = pc_f_q + DATA_WIDTH'(4);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          state_d = S_REQ;
          if (drop_q || pc_src_i) begin
            drop_d = 1'b0;
          end else if (ifid_free) begin
            new_vld = 1'b1;
          end else begin
            buf_instr_d = imem.rdata;
            buf_pc_d    = pc_if_q;
            state_d     = S_HOLD;
          end
        end else if (pc_src_i) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (pc_src_i) begin
          state_d = S_REQ;
        end else if (!stall_d_i) begin
          new_vld   = 1'b1;
          new_instr = buf_instr_q;
          new_pc    = buf_pc_q;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (pc_src_i) begin
      pc_f_d = pc_target_i;
    end
  end

  always_comb begin
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;
    if (pc_src_i || flush_d_i) begin
      valid_d_d = 1'b0;
    end else if (!(stall_d_i && valid_d_q)) begin
      if (new_vld) begin
        instr_d_d    = new_instr;
        pc_d_d       = new_pc;
        pc_plus4_d_d = new_pc + DATA_WIDTH'(4);
        valid_d_d    = 1'b1;
      end else begin
        valid_d_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_f_q       <= RESET_PC;
      pc_if_q      <= '0;
      drop_q       <= 1'b0;
      buf_instr_q  <= '0;
      buf_pc_q     <= '0;
      instr_d_q    <= '0;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      pc_if_q      <= pc_if_d;
      drop_q       <= drop_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
    end
  end

  assign instr_d_o    = instr_d_q;
  assign pc_d_o       = pc_d_q;
  assign pc_plus4_d_o = pc_plus4_d_q;
  assign valid_d_o    = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a transaction-level model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] target = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        gnt_en = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  int          lat = 1;

  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.DATA_WIDTH(32)) imem_bus ();
  assign imem_bus.gnt    = gnt_en;
  assign imem_bus.rvalid = rvalid;
  assign imem_bus.rdata  = rdata;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_src_i     (pc_src),
    .pc_target_i  (target),
    .stall_d_i    (stall),
    .flush_d_i    (flush),
    .imem         (imem_bus.master),
    .instr_d_o    (instr_d),
    .pc_d_o       (pc_d),
    .pc_plus4_d_o (pc_plus4_d),
    .valid_d_o    (valid_d)
  );

  // Second instance: PC wrap-around at the top of the address space.
  logic        rvalid2 = 1'b0;
  logic        acc2 = 1'b0;
  logic [31:0] instr2, pc2, p42;
  logic        valid2;
  fetch_stage_if #(.DATA_WIDTH(32)) imem2 ();
  assign imem2.gnt    = 1'b1;
  assign imem2.rvalid = rvalid2;
  assign imem2.rdata  = 32'h0000_0013;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_src_i     (1'b0),
    .pc_target_i  (32'h0),
    .stall_d_i    (1'b0),
    .flush_d_i    (1'b0),
    .imem         (imem2.master),
    .instr_d_o    (instr2),
    .pc_d_o       (pc2),
    .pc_plus4_d_o (p42),
    .valid_d_o    (valid2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory slave: fixed-latency responses, rdata derived from the address.
  int          cyc = 0;
  logic        acc_s = 1'b0;
  logic [31:0] acc_addr_s = '0;
  int          pend_due[$];
  logic [31:0] pend_addr[$];

  always @(negedge clk) begin
    acc_s      = imem_bus.req & imem_bus.gnt;
    acc_addr_s = imem_bus.addr;
    acc2       = imem2.req;
  end

  always @(posedge clk) begin
    cyc++;
    if (acc_s) begin
      pend_due.push_back(cyc - 1 + lat);
      pend_addr.push_back(acc_addr_s);
    end
    #1;
    rvalid2 = acc2;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      rvalid = 1'b1;
      rdata  = 32'h1357_0000 ^ pend_addr[0];
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  end

  // Model: one fetch in flight at most; a squashed fetch still owes its response.
  logic [31:0] m_pc, m_fetch_pc, m_buf_instr, m_buf_pc;
  logic [31:0] m_if_instr, m_if_pc, m_if_plus4;
  bit          m_busy, m_squash, m_held, m_if_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_fetch_pc = '0; m_buf_instr = '0; m_buf_pc = '0;
    m_if_instr = '0; m_if_pc = '0; m_if_plus4 = '0;
    m_busy = 0; m_squash = 0; m_held = 0; m_if_valid = 0;
  endtask

  task automatic model_step();
    bit          got = 0;
    logic [31:0] g_instr = '0;
    logic [31:0] g_pc = '0;
    if (m_held) begin
      if (pc_src) m_held = 0;
      else if (!stall) begin got = 1; g_instr = m_buf_instr; g_pc = m_buf_pc; m_held = 0; end
    end else if (m_busy) begin
      if (rvalid) begin
        m_busy = 0;
        if (m_squash || pc_src) m_squash = 0;
        else if (!m_if_valid || !stall) begin got = 1; g_instr = rdata; g_pc = m_fetch_pc; end
        else begin m_held = 1; m_buf_instr = rdata; m_buf_pc = m_fetch_pc; end
      end else if (pc_src) begin
        m_squash = 1;
      end
    end else if (!pc_src && gnt_en) begin
      m_busy = 1; m_fetch_pc = m_pc; m_pc = m_pc + 32'd4;
    end
    if (pc_src) m_pc = target;
    if (pc_src || flush) m_if_valid = 0;
    else if (stall && m_if_valid) m_if_valid = 1;
    else if (got) begin
      m_if_valid = 1; m_if_instr = g_instr; m_if_pc = g_pc; m_if_plus4 = g_pc + 32'd4;
    end else m_if_valid = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("req", imem_bus.req, rst_n && !m_busy && !m_held && !pc_src);
    chk("addr", imem_bus.addr, m_pc);
    chk("valid_d", valid_d, m_if_valid);
    chk("instr_d", instr_d, m_if_instr);
    chk("pc_d", pc_d, m_if_pc);
    chk("pc_plus4_d", pc_plus4_d, m_if_plus4);
  end

  logic [31:0] u2_addr_q[$];
  bit          u2_seen = 0;
  logic [31:0] u2_pc = '0, u2_p4 = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem2.req && u2_addr_q.size() < 2) u2_addr_q.push_back(imem2.addr);
      if (valid2 && !u2_seen) begin u2_seen = 1; u2_pc = pc2; u2_p4 = p42; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    gnt_en = 1'b1;
    repeat (2) tick();
    #1;
    chk("rst_req", imem_bus.req, 0);
    chk("rst_valid", valid_d, 0);
    chk("rst_pc_d", pc_d, 0);
    chk("rst_instr", instr_d, 0);
    chk("rst_addr", imem_bus.addr, 0);
    rst_n = 1'b1;                                      // c0
    #1 chk("c0_req", imem_bus.req, 1);
    tick(); tick();                                    // c2
    chk("s1_valid0", valid_d, 1);
    chk("s1_pc0", pc_d, 32'h0);
    chk("s1_p4_0", pc_plus4_d, 32'h4);
    chk("s1_instr0", instr_d, 32'h1357_0000);
    chk("s1_addr4", imem_bus.addr, 32'h4);
    tick();                                            // c3
    chk("s1_bubble", valid_d, 0);
    tick();                                            // c4
    chk("s1_pc4", pc_d, 32'h4);
    chk("s1_p4_4", pc_plus4_d, 32'h8);
    chk("s1_addr8", imem_bus.addr, 32'h8);
    lat = 2;
    tick();                                            // c5: waiting for addr 8
    pc_src = 1'b1; target = 32'h40;
    tick();                                            // c6: stale addr-8 response
    pc_src = 1'b0;
    chk("s2_valid_c6", valid_d, 0);
    tick();                                            // c7
    chk("s2_valid_c7", valid_d, 0);
    chk("s2_addr", imem_bus.addr, 32'h40);
    #1 chk("s2_req", imem_bus.req, 1);
    tick();                                            // c8
    lat = 1;
    tick(); tick();                                    // c10
    chk("s3_pc40", pc_d, 32'h40);
    chk("s3_addr44", imem_bus.addr, 32'h44);
    stall = 1'b1;
    tick(); tick();                                    // c12: HOLD
    chk("s3_held_valid", valid_d, 1);
    chk("s3_held_pc", pc_d, 32'h40);
    #1 chk("s3_hold_noreq", imem_bus.req, 0);
    tick();                                            // c13
    chk("s3_held_pc2", pc_d, 32'h40);
    stall = 1'b0;
    tick();                                            // c14
    chk("s3_buf_valid", valid_d, 1);
    chk("s3_buf_pc", pc_d, 32'h44);
    chk("s3_buf_instr", instr_d, 32'h1357_0044);
    chk("s3_resume_addr", imem_bus.addr, 32'h48);
    #1 chk("s3_resume_req", imem_bus.req, 1);
    tick();                                            // c15: rvalid in WAIT
    pc_src = 1'b1; target = 32'h100; flush = 1'b1;
    #1 chk("s4_noreq", imem_bus.req, 0);
    tick();                                            // c16
    pc_src = 1'b0; flush = 1'b0;
    chk("s4_valid", valid_d, 0);
    chk("s4_pcf", imem_bus.addr, 32'h100);
    pc_src = 1'b1; target = 32'h200;
    #1 chk("redir_noreq", imem_bus.req, 0);
    tick();                                            // c17
    pc_src = 1'b0;
    chk("redir_addr", imem_bus.addr, 32'h200);
    tick(); tick();                                    // c19
    chk("redir_pc", pc_d, 32'h200);
    chk("redir_p4", pc_plus4_d, 32'h204);
    flush = 1'b1;
    tick();                                            // c20
    flush = 1'b0;
    chk("flush_valid", valid_d, 0);
    chk("flush_pc_hold", pc_d, 32'h200);
    tick();                                            // c21
    chk("after_flush_pc", pc_d, 32'h204);

    for (int i = 0; i < 300; i++) begin
      pc_src = ($urandom_range(0, 9) == 0);
      target = $urandom;
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      gnt_en = ($urandom_range(0, 3) != 0);
      lat    = $urandom_range(1, 3);
      tick();
    end

    pc_src = 1'b0; stall = 1'b0; flush = 1'b0; gnt_en = 1'b0;
    repeat (6) tick();
    lat = 3; gnt_en = 1'b1;
    tick();                                            // in WAIT, response due in 2 cycles
    gnt_en = 1'b0; rst_n = 1'b0;
    #1;
    chk("s6_rst_req", imem_bus.req, 0);
    chk("s6_rst_valid", valid_d, 0);
    chk("s6_rst_addr", imem_bus.addr, 32'h0);
    chk("s6_rst_pc_d", pc_d, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();                                            // stale response arrives in REQ
    tick();
    chk("s6_stale_ignored", valid_d, 0);
    chk("s6_first_addr", imem_bus.addr, 32'h0);
    lat = 1; gnt_en = 1'b1;
    tick(); tick();
    chk("s6_valid", valid_d, 1);
    chk("s6_pc", pc_d, 32'h0);
    chk("s6_instr", instr_d, 32'h1357_0000);

    chk("s5_seen", u2_seen, 1);
    chk("s5_pc", u2_pc, 32'hFFFF_FFFC);
    chk("s5_p4", u2_p4, 32'h0);
    chk("s5_nreq", u2_addr_q.size(), 2);
    if (u2_addr_q.size() == 2) begin
      chk("s5_addr0", u2_addr_q[0], 32'hFFFF_FFFC);
      chk("s5_addr1", u2_addr_q[1], 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
